// File: rtl/arm32_cpu_pkg.sv
// arm32_cpu_pkg: shared types and constants for the arm32_cpu core.
//   state_t  - multicycle sequencer states
//   dp_op_t  - data-processing opcodes (instr[24:21])
//   shift_t  - barrel shifter types (instr[6:5])
//   COND_*   - condition field encodings, FLAG_* - bit positions in the NZCV nibble
//   ror32    - 32-bit rotate right helper
//   cond_ok  - condition evaluation against NZCV
package arm32_cpu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_PC   = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } dp_op_t;

  typedef enum logic [1:0] {
    SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3
  } shift_t;

  localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                         COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                         COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                         COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // A shift by 32 yields 0, so n == 0 returns x unchanged.
  function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
    ror32 = (x >> n) | (x << (6'd32 - {1'b0, n}));
  endfunction

  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[FLAG_N];
    z = f[FLAG_Z];
    c = f[FLAG_C];
    v = f[FLAG_V];
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = !z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = !c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = !n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = !v;
      COND_HI: cond_ok = c && !z;
      COND_LS: cond_ok = !c || z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = !z && (n == v);
      COND_LE: cond_ok = z || (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/arm32_cpu_alu.sv
// arm32_alu: combinational barrel shifter (operand2 generation) plus ALU.
//   opcode    - data-processing opcode
//   imm_op    - I bit: operand2 is a rotated immediate
//   op2_field - instr[11:0]
//   rn_val    - first operand (Rn)
//   rm_val    - register operand (Rm) for shifted-register forms
//   rs_amt    - Rs[7:0] for register-specified shift amounts
//   result    - 32-bit result
//   nzcv      - flags computed from this result
module arm32_alu
  import arm32_cpu_pkg::*;
(
  input  dp_op_t      opcode,
  input  logic        imm_op,
  input  logic [11:0] op2_field,
  input  logic [31:0] rn_val,
  input  logic [31:0] rm_val,
  input  logic [7:0]  rs_amt,
  output logic [31:0] result,
  output logic [3:0]  nzcv
);

  logic [31:0] operand2;
  logic [7:0]  shift_amt;
  logic [32:0] sum;
  logic        carry;
  logic        ovf;

  always_comb begin
    operand2  = '0;
    shift_amt = '0;
    if (imm_op) begin
      operand2 = ror32({24'd0, op2_field[7:0]}, {op2_field[11:8], 1'b0});
    end else begin
      shift_amt = op2_field[4] ? rs_amt : {3'd0, op2_field[11:7]};
      case (shift_t'(op2_field[6:5]))
        SH_LSL: operand2 = (shift_amt > 8'd31) ? '0 : (rm_val << shift_amt[4:0]);
        SH_LSR: operand2 = (shift_amt > 8'd31) ? '0 : (rm_val >> shift_amt[4:0]);
        SH_ASR: operand2 = (shift_amt > 8'd31) ? {32{rm_val[31]}}
                                               : $unsigned($signed(rm_val) >>> shift_amt[4:0]);
        SH_ROR: operand2 = ror32(rm_val, shift_amt[4:0]);
        default: operand2 = rm_val;
      endcase
    end
  end

  // Subtract carry is a borrow flag (set when the minuend is smaller).
  always_comb begin
    sum    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    result = '0;
    case (opcode)
      OP_AND, OP_TST: result = rn_val & operand2;
      OP_EOR, OP_TEQ: result = rn_val ^ operand2;
      OP_SUB, OP_CMP: begin
        result = rn_val - operand2;
        carry  = rn_val < operand2;
        ovf    = (rn_val[31] ^ operand2[31]) & (result[31] ^ rn_val[31]);
      end
      OP_RSB: begin
        result = operand2 - rn_val;
        carry  = operand2 < rn_val;
        ovf    = (operand2[31] ^ rn_val[31]) & (result[31] ^ operand2[31]);
      end
      OP_ADD, OP_CMN: begin
        sum    = {1'b0, rn_val} + {1'b0, operand2};
        result = sum[31:0];
        carry  = sum[32];
        ovf    = ~(rn_val[31] ^ operand2[31]) & (result[31] ^ rn_val[31]);
      end
      OP_ORR: result = rn_val | operand2;
      OP_MOV: result = operand2;
      OP_BIC: result = rn_val & ~operand2;
      OP_MVN: result = ~operand2;
      default: result = '0;
    endcase
  end

  assign nzcv = {result[31], (result == 32'd0), carry, ovf};

endmodule

// File: rtl/arm32_cpu.sv
// arm32_cpu: multicycle, non-pipelined ARM32-subset core.
//   clk, rst_n          - clock; asynchronous reset, active-high despite the name
//   instr / pc_out      - instruction port (word address, read data)
//   ram_data2           - data-port read data
//   ram_w_en2/addr2/in2 - data-port write strobe, word address, write data
//   ram_w_en1           - instruction-port write enable, always 0
//   start_pc            - PC loaded after reset
//   waiting             - high while in LOAD_PC
//   status_out          - {N,Z,C,V} in [31:28]
//   datapath_out        - last ALU/shifter result
//   reg_addr/reg_output - debug register read
// Optional build macro ARM32_COND_EXEC_EN enables condition-field evaluation.
//
// state        | meaning
// LOAD_PC      | load pc from start_pc
// FETCH        | IR <= instr at pc
// DECODE       | latch Rn, Rm, Rs[7:0], Rd values
// EXECUTE      | register result/flags, or data-port address/strobe
// MEM          | data-port access (LDR/STR only)
// WRITEBACK    | write Rd, advance pc or branch
module arm32_cpu
  import arm32_cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic [31:0] ram_data2,
  input  logic [10:0] start_pc,
  input  logic [3:0]  reg_addr,
  output logic        waiting,
  output logic        ram_w_en1,
  output logic        ram_w_en2,
  output logic [10:0] ram_addr2,
  output logic [31:0] ram_in2,
  output logic [31:0] status_out,
  output logic [31:0] datapath_out,
  output logic [10:0] pc_out,
  output logic [31:0] reg_output
);

  state_t      state;
  logic [10:0] pc;
  logic [31:0] ir;
  logic [3:0]  nzcv;
  logic [31:0] a_q, b_q, rd_q;
  logic [7:0]  rs_q;
  logic        wb_en, wb_from_mem, take_br;
  logic [31:0] regs [16];

  logic [31:0] alu_result;
  logic [3:0]  alu_nzcv;
  logic        cond_pass;
  logic        is_dp, is_ldst, is_branch, is_test, is_nop;
  logic [10:0] ls_addr;

  assign is_dp     = (ir[27:26] == 2'b00);
  assign is_ldst   = (ir[27:26] == 2'b01);
  assign is_branch = (ir[27:25] == 3'b101);
  assign is_test   = (ir[24:23] == 2'b10);
  // ADC, SBC, RSC
  assign is_nop    = (ir[24:23] == 2'b01) && (ir[22:21] != 2'b00);
  // Only the low 11 bits matter since the address is truncated anyway.
  assign ls_addr   = ir[23] ? (a_q[10:0] + ir[10:0]) : (a_q[10:0] - ir[10:0]);

`ifdef ARM32_COND_EXEC_EN
  assign cond_pass = cond_ok(ir[31:28], nzcv);
`else
  assign cond_pass = 1'b1;
`endif

  arm32_alu u_alu (
    .opcode    (dp_op_t'(ir[24:21])),
    .imm_op    (ir[25]),
    .op2_field (ir[11:0]),
    .rn_val    (a_q),
    .rm_val    (b_q),
    .rs_amt    (rs_q),
    .result    (alu_result),
    .nzcv      (alu_nzcv)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state        <= ST_LOAD_PC;
      pc           <= '0;
      ir           <= '0;
      nzcv         <= '0;
      datapath_out <= '0;
      ram_w_en2    <= 1'b0;
      ram_addr2    <= '0;
      ram_in2      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rd_q         <= '0;
      rs_q         <= '0;
      wb_en        <= 1'b0;
      wb_from_mem  <= 1'b0;
      take_br      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD_PC: begin
          pc    <= start_pc;
          state <= ST_FETCH;
        end
        ST_FETCH: begin
          ir    <= instr;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          a_q   <= regs[ir[19:16]];
          b_q   <= regs[ir[3:0]];
          rs_q  <= regs[ir[11:8]][7:0];
          rd_q  <= regs[ir[15:12]];
          state <= ST_EXECUTE;
        end
        ST_EXECUTE: begin
          wb_en       <= 1'b0;
          wb_from_mem <= 1'b0;
          take_br     <= 1'b0;
          state       <= ST_WRITEBACK;
          if (is_dp) begin
            if (cond_pass && !is_nop) begin
              datapath_out <= alu_result;
              if (ir[20] || is_test) nzcv <= alu_nzcv;
              wb_en <= !is_test;
            end
          end else if (is_ldst) begin
            state       <= ST_MEM;
            ram_addr2   <= ls_addr;
            ram_in2     <= rd_q;
            ram_w_en2   <= cond_pass && !ir[20];
            wb_en       <= cond_pass && ir[20];
            wb_from_mem <= 1'b1;
          end else if (is_branch) begin
            take_br <= cond_pass;
          end
        end
        ST_MEM: begin
          ram_w_en2 <= 1'b0;
          state     <= ST_WRITEBACK;
        end
        ST_WRITEBACK: begin
          pc    <= pc + 11'd1 + (take_br ? ir[10:0] : 11'd0);
          state <= ST_FETCH;
        end
        default: state <= ST_LOAD_PC;
      endcase
    end
  end

  // Register file has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (!rst_n && state == ST_WRITEBACK && wb_en)
      regs[ir[15:12]] <= wb_from_mem ? ram_data2 : datapath_out;
  end

  assign waiting    = (state == ST_LOAD_PC);
  assign ram_w_en1  = 1'b0;
  assign pc_out     = pc;
  assign status_out = {nzcv, 28'd0};
  assign reg_output = regs[reg_addr];

endmodule

// File: tb/tb_arm32_cpu.sv
module tb_arm32_cpu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic [31:0] ram_data2;
  logic [10:0] start_pc;
  logic [3:0]  reg_addr;
  logic        waiting, ram_w_en1, ram_w_en2;
  logic [10:0] ram_addr2, pc_out;
  logic [31:0] ram_in2, status_out, datapath_out, reg_output;

  logic [31:0] imem [2048];
  logic [31:0] dmem [2048];
  int checks = 0;
  int failures = 0;
  int wcount = 0;

  arm32_cpu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .ram_data2    (ram_data2),
    .start_pc     (start_pc),
    .reg_addr     (reg_addr),
    .waiting      (waiting),
    .ram_w_en1    (ram_w_en1),
    .ram_w_en2    (ram_w_en2),
    .ram_addr2    (ram_addr2),
    .ram_in2      (ram_in2),
    .status_out   (status_out),
    .datapath_out (datapath_out),
    .pc_out       (pc_out),
    .reg_output   (reg_output)
  );

  always #5 clk = ~clk;

  assign instr     = imem[pc_out];
  assign ram_data2 = dmem[ram_addr2];

  always @(posedge clk) begin
    if (ram_w_en2) begin
      dmem[ram_addr2] <= ram_in2;
      wcount = wcount + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [31:0] exp);
    reg_addr = 4'(idx);
    #1;
    check(tag, reg_output, exp);
  endtask

  task automatic do_reset(input logic [10:0] sp);
    rst_n    = 1'b1;
    start_pc = sp;
    tick(1);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b1;
    start_pc = 11'd0;
    reg_addr = 4'd0;
    for (int i = 0; i < 2048; i++) begin
      imem[i] = 32'hE1A0_0000;   // MOV R0,R0
      dmem[i] = 32'd0;
    end
    dmem[11'h03C] = 32'hCAFE_BABE;
    for (int k = 0; k < 16; k++) imem[k] = 32'hE3A0_0001 + 32'(k) * 32'h1001;
    imem[100] = 32'hE3A0_0001;  // MOV R0,#1
    imem[101] = 32'hE090_0000;  // ADDS R0,R0,R0
    imem[102] = 32'hE3A0_2003;  // MOV R2,#3
    imem[103] = 32'hE082_2210;  // ADD R2,R2,R0 LSL R2
    imem[104] = 32'hE3A0_5006;  // MOV R5,#6
    imem[105] = 32'hE3A0_100C;  // MOV R1,#12
    imem[106] = 32'hE3A0_3004;  // MOV R3,#4
    imem[107] = 32'hE045_5331;  // SUB R5,R5,R1 LSR R3
    imem[108] = 32'hE3A0_000E;  // MOV R0,#14
    imem[109] = 32'hE150_0001;  // CMP R0,R1
    imem[110] = 32'hE050_0000;  // SUBS R0,R0,R0
    imem[111] = 32'hE3A0_6040;  // MOV R6,#0x40
    imem[112] = 32'hE3A0_7055;  // MOV R7,#0x55
    imem[113] = 32'hE586_7004;  // STR R7,[R6,#4]
    imem[114] = 32'hE596_8004;  // LDR R8,[R6,#4]
    imem[115] = 32'hE516_9004;  // LDR R9,[R6,#-4]
    imem[116] = 32'hEA00_0002;  // B +2 -> 119
    imem[117] = 32'hE3A0_A0BB;  // MOV R10,#0xBB (skipped)
    imem[118] = 32'hE3A0_A0BB;
    imem[119] = 32'hE3A0_A077;  // MOV R10,#0x77
    imem[200] = 32'hE3A0_B099;  // MOV R11,#0x99 (aborted)
    imem[400] = 32'hE3A0_1102;  // MOV R1,#0x80000000
    imem[401] = 32'hE3A0_3028;  // MOV R3,#40
    imem[402] = 32'hE1A0_4351;  // MOV R4,R1,ASR R3
    imem[403] = 32'hE1A0_5331;  // MOV R5,R1,LSR R3
    imem[404] = 32'hE1A0_6371;  // MOV R6,R1,ROR R3
    imem[405] = 32'hE1A0_7081;  // MOV R7,R1,LSL #1
    imem[406] = 32'hE3F0_8000;  // MVNS R8,#0
    imem[407] = 32'hE2A9_9001;  // ADC R9,R9,#1 (NOP)

    // reset values
    tick(1);
    check("rst_waiting", 32'(waiting), 32'd1);
    check("rst_pc", 32'(pc_out), 32'd0);
    check("rst_status", status_out, 32'd0);
    check("rst_dp", datapath_out, 32'd0);
    check("rst_wen2", 32'(ram_w_en2), 32'd0);
    check("rst_addr2", 32'(ram_addr2), 32'd0);
    check("rst_in2", ram_in2, 32'd0);
    check("rst_wen1", 32'(ram_w_en1), 32'd0);

    // MOV Rk,#(k+1), one reset per instruction
    for (int k = 0; k < 16; k++) begin
      do_reset(11'(k));
      tick(1);
      check("mov_pc", 32'(pc_out), 32'(k));
      tick(3);
      check("mov_dp", datapath_out, 32'(k + 1));
      tick(1);
      check_reg("mov_rk", k, 32'(k + 1));
      tick(1);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 16; k++) check_reg("mov_all", k, 32'(k + 1));

    // arithmetic / shift / compare / memory / branch program
    do_reset(11'd100);
    tick(1);
    tick(4);
    tick(3);
    check("adds_dp", datapath_out, 32'd2);
    check("adds_st", status_out, 32'd0);
    tick(1);
    check_reg("adds_r0", 0, 32'd2);
    tick(4);
    tick(4);
    check("add_lsl_dp", datapath_out, 32'd19);
    check_reg("add_lsl_r2", 2, 32'd19);
    tick(12);
    tick(4);
    check("sub_lsr_dp", datapath_out, 32'd6);
    check_reg("sub_lsr_r5", 5, 32'd6);
    check("sub_lsr_st", status_out, 32'd0);
    tick(4);
    tick(3);
    check("cmp_dp", datapath_out, 32'd2);
    check("cmp_st", status_out, 32'd0);
    tick(1);
    check_reg("cmp_r0", 0, 32'd14);
    tick(4);
    check("subs_dp", datapath_out, 32'd0);
    check("subs_st", status_out, 32'h4000_0000);
    check_reg("subs_r0", 0, 32'd0);
    tick(8);
    tick(3);
    check("str_wen", 32'(ram_w_en2), 32'd1);
    check("str_addr", 32'(ram_addr2), 32'h44);
    check("str_data", ram_in2, 32'h55);
    tick(1);
    check("str_wen_off", 32'(ram_w_en2), 32'd0);
    tick(1);
    check("str_count", 32'(wcount), 32'd1);
    check("str_mem", dmem[11'h044], 32'h55);
    tick(5);
    check_reg("ldr_r8", 8, 32'h55);
    tick(3);
    check("ldr_neg_addr", 32'(ram_addr2), 32'h3C);
    check("ldr_wen", 32'(ram_w_en2), 32'd0);
    tick(2);
    check_reg("ldr_r9", 9, 32'hCAFE_BABE);
    tick(4);
    check("branch_pc", 32'(pc_out), 32'd119);
    tick(4);
    check_reg("branch_r10", 10, 32'h77);

    // reset asserted during EXECUTE
    do_reset(11'd200);
    tick(3);
    rst_n    = 1'b1;
    start_pc = 11'd300;
    #1;
    check("abort_waiting", 32'(waiting), 32'd1);
    check("abort_pc", 32'(pc_out), 32'd0);
    check("abort_dp", datapath_out, 32'd0);
    tick(1);
    rst_n = 1'b0;
    check_reg("abort_r11", 11, 32'd12);
    tick(1);
    check("abort_pc_load", 32'(pc_out), 32'd300);
    check("abort_wait_lo", 32'(waiting), 32'd0);
    tick(3);
    check_reg("abort_r11_late", 11, 32'd12);

    // pc wrap
    do_reset(11'd2047);
    tick(5);
    check("pc_wrap", 32'(pc_out), 32'd0);

    // shifter boundaries, MVNS, ADC as NOP
    do_reset(11'd400);
    tick(1);
    tick(3);
    check("imm_rot_dp", datapath_out, 32'h8000_0000);
    tick(5);
    tick(3);
    check("asr40_dp", datapath_out, 32'hFFFF_FFFF);
    tick(1);
    check_reg("asr40_r4", 4, 32'hFFFF_FFFF);
    tick(3);
    check("lsr40_dp", datapath_out, 32'd0);
    tick(4);
    check("ror40_dp", datapath_out, 32'h0080_0000);
    tick(4);
    check("lsl1_dp", datapath_out, 32'd0);
    tick(4);
    check("mvns_dp", datapath_out, 32'hFFFF_FFFF);
    check("mvns_st", status_out, 32'h8000_0000);
    tick(4);
    check("adc_nop_dp", datapath_out, 32'hFFFF_FFFF);
    check_reg("adc_nop_r9", 9, 32'hCAFE_BABE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
